// File: rtl/regfile_mp.sv
// Multi-port register file: byte-enable writes, optional same-cycle write-to-read bypass, hardware clear sweep.
// Latency: reads are combinational (zero cycles); writes land on the next rising edge; the sweep takes REGISTERS cycles.
// Backpressure: ready=0 during the sweep; writes are dropped and reads return 0 until ready rises.
// Ports: clk/rst (sync active-high); we/wa/wd/wbe per write port; ra/rd per read lane; ready = sweep done.
module regfile_mp #(
  parameter int DATAWIDTH   = 32,
  parameter int REGISTERS   = 32,
  parameter int INDEX       = $clog2(REGISTERS),
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int BYPASS      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WRITE_PORTS-1:0]            we,
  input  logic [WRITE_PORTS*INDEX-1:0]      wa,
  input  logic [WRITE_PORTS*DATAWIDTH-1:0]  wd,
  input  logic [WRITE_PORTS*DATAWIDTH/8-1:0] wbe,
  input  logic [READ_PORTS*INDEX-1:0]       ra,
  output logic [READ_PORTS*DATAWIDTH-1:0]   rd,
  output logic                              ready
);

  localparam int BYTES = DATAWIDTH / 8;
  localparam logic [INDEX:0]   REG_LIM = (INDEX + 1)'(REGISTERS);
  localparam logic [INDEX-1:0] LAST    = INDEX'(REGISTERS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX-1:0]       clr_cnt_q, clr_cnt_d;
  logic [DATAWIDTH-1:0]   regs_q [REGISTERS];
  logic [DATAWIDTH-1:0]   regs_d [REGISTERS];

  // Address 0 is the hardwired zero register; anything at or past REGISTERS
  // only exists when the depth is not a power of two and is treated as absent.
  function automatic logic addr_ok(input logic [INDEX-1:0] a);
    return (a != '0) && ({1'b0, a} < REG_LIM);
  endfunction

  assign ready = (state_q == RUN);

  // Next state: one entry cleared per cycle in CLEAR, byte-merged writes in RUN.
  // Ports are applied in ascending order so the highest-numbered port wins each byte.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    regs_d    = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clr_cnt_q] = '0;
      clr_cnt_d         = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) begin
        state_d = RUN;
      end
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (we[p] && addr_ok(wa[p*INDEX +: INDEX])) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wbe[p*BYTES + b]) begin
              regs_d[wa[p*INDEX +: INDEX]][b*8 +: 8] = wd[p*DATAWIDTH + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Contents are held while rst is high; only the sweep that follows initialises them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      regs_q    <= regs_d;
    end
  end

  // Read lanes: zero while clearing or for x0/out-of-range, otherwise stored
  // value with optional per-byte forwarding from this cycle's writes.
  always_comb begin
    rd = '0;
    for (int q = 0; q < READ_PORTS; q++) begin
      if ((state_q == RUN) && addr_ok(ra[q*INDEX +: INDEX])) begin
        rd[q*DATAWIDTH +: DATAWIDTH] = regs_q[ra[q*INDEX +: INDEX]];
        if (BYPASS != 0) begin
          for (int p = 0; p < WRITE_PORTS; p++) begin
            if (we[p] && (wa[p*INDEX +: INDEX] == ra[q*INDEX +: INDEX])) begin
              for (int b = 0; b < BYTES; b++) begin
                if (wbe[p*BYTES + b]) begin
                  rd[q*DATAWIDTH + b*8 +: 8] = wd[p*DATAWIDTH + b*8 +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

endmodule
